cic_decim_mc: RTL and testbench

- Multi-channel, parametrised CIC decimator that replaces the single-channel, fixed-rate cic_decim plus its external decimation counter.
- Generates its own decimation strobe from a programmable rate, qualifies input samples with an input strobe, and applies programmable gain normalisation with rounding and saturation.
- Sits between the DDC/mixer outputs and the RX FIFO packer in the 120 MHz domain; one instance handles all channels (e.g. I/Q) in lockstep.

---
 rtl/cic_decim_mc.sv | 128 ++++++++++++
 tb/tb_cic_decim_mc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: one shared decimation counter, STAGES integrator and
// comb stages per channel, then rounded right-shift and saturation to OUT_WIDTH.
module cic_decim_mc #(
  parameter int CHANNELS   = 2,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int STAGES     = 4,
  parameter int RATE_WIDTH = 8
) (
  input  logic                          clk_120mhz,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [RATE_WIDTH-1:0]         rate,
  input  logic [5:0]                    shift,
  input  logic                          in_strobe,
  input  logic [CHANNELS*IN_WIDTH-1:0]  signal_in,
  output logic                          out_strobe,
  output logic [CHANNELS*OUT_WIDTH-1:0] signal_out
);
  localparam int ACC_WIDTH = IN_WIDTH + STAGES * RATE_WIDTH;
  localparam int V_WIDTH   = ACC_WIDTH + 1;

  // One extra bit so adding the rounding half never overflows before the shift.
  function automatic logic [OUT_WIDTH-1:0] round_sat(input logic [ACC_WIDTH-1:0] x,
                                                     input logic [5:0] sh);
    logic [V_WIDTH-1:0]   v;
    logic [V_WIDTH-1:0]   half;
    logic [OUT_WIDTH-1:0] res;
    half = {{(V_WIDTH-1){1'b0}}, 1'b1};
    v    = {x[ACC_WIDTH-1], x};
    if (int'(sh) >= ACC_WIDTH) begin
      v = {V_WIDTH{x[ACC_WIDTH-1]}};
    end else begin
      v = v + ((sh != 6'd0) ? (half << (sh - 6'd1)) : {V_WIDTH{1'b0}});
      v = $signed(v) >>> sh;
    end
    if (v[V_WIDTH-1:OUT_WIDTH-1] == {(V_WIDTH-OUT_WIDTH+1){v[V_WIDTH-1]}}) begin
      res = v[OUT_WIDTH-1:0];
    end else begin
      res = {v[V_WIDTH-1], {(OUT_WIDTH-1){~v[V_WIDTH-1]}}};
    end
    return res;
  endfunction

  logic [RATE_WIDTH-1:0] r_count;
  logic [ACC_WIDTH-1:0]  r_integ     [CHANNELS][STAGES];
  logic [ACC_WIDTH-1:0]  r_comb_prev [CHANNELS][STAGES];
  logic [ACC_WIDTH-1:0]  r_comb_out  [CHANNELS];
  logic                  r_comb_en;
  logic                  r_comb_valid;
  logic [ACC_WIDTH-1:0]  w_stage_in  [CHANNELS][STAGES];
  logic [ACC_WIDTH-1:0]  w_comb_res  [CHANNELS];
  logic                  w_accept;
  logic                  w_dstrobe;
  logic [RATE_WIDTH-1:0] w_reload;

  assign w_accept  = in_strobe & enable;
  assign w_dstrobe = w_accept & (r_count == {RATE_WIDTH{1'b0}});
  assign w_reload  = (rate == {RATE_WIDTH{1'b0}}) ? {RATE_WIDTH{1'b0}} : (rate - RATE_WIDTH'(1));

  // Comb stages evaluated as one combinational difference chain.
  always_comb begin : comb_chain
    logic [ACC_WIDTH-1:0] acc;
    acc = {ACC_WIDTH{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      acc = r_integ[c][STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        w_stage_in[c][k] = acc;
        acc = acc - r_comb_prev[c][k];
      end
      w_comb_res[c] = acc;
    end
  end

  always_ff @(posedge clk_120mhz) begin
    if (reset || !enable) begin
      r_count      <= {RATE_WIDTH{1'b0}};
      r_comb_en    <= 1'b0;
      r_comb_valid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_comb_out[c] <= {ACC_WIDTH{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
          r_integ[c][k]     <= {ACC_WIDTH{1'b0}};
          r_comb_prev[c][k] <= {ACC_WIDTH{1'b0}};
        end
      end
    end else begin
      r_comb_en    <= w_dstrobe;
      r_comb_valid <= r_comb_en;
      if (w_accept) begin
        r_count <= w_dstrobe ? w_reload : (r_count - RATE_WIDTH'(1));
        for (int c = 0; c < CHANNELS; c++) begin
          r_integ[c][0] <= r_integ[c][0] +
            {{(ACC_WIDTH-IN_WIDTH){signal_in[c*IN_WIDTH+IN_WIDTH-1]}},
             signal_in[c*IN_WIDTH +: IN_WIDTH]};
          for (int k = 1; k < STAGES; k++) begin
            r_integ[c][k] <= r_integ[c][k] + r_integ[c][k-1];
          end
        end
      end
      if (r_comb_en) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_comb_out[c] <= w_comb_res[c];
          for (int k = 0; k < STAGES; k++) begin
            r_comb_prev[c][k] <= w_stage_in[c][k];
          end
        end
      end
    end
  end

  // Output register holds its value while disabled; only reset clears it.
  always_ff @(posedge clk_120mhz) begin
    if (reset) begin
      out_strobe <= 1'b0;
      signal_out <= {(CHANNELS*OUT_WIDTH){1'b0}};
    end else if (!enable) begin
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= r_comb_valid;
      if (r_comb_valid) begin
        for (int c = 0; c < CHANNELS; c++) begin
          signal_out[c*OUT_WIDTH +: OUT_WIDTH] <= round_sat(r_comb_out[c], shift);
        end
      end
    end
  end
endmodule

// File: tb/tb_cic_decim_mc.sv
// Scoreboard bench for cic_decim_mc: a sample-history CIC model predicts each output,
// a negedge monitor pops and compares whenever out_strobe is seen.
module tb_cic_decim_mc;
  localparam int CH = 2;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int NS = 4;
  localparam int RW = 8;
  localparam int AW = IW + NS * RW;

  logic             clk_120mhz = 1'b0;
  logic             reset;
  logic             enable;
  logic [RW-1:0]    rate;
  logic [5:0]       shift;
  logic             in_strobe;
  logic [CH*IW-1:0] signal_in;
  logic             out_strobe;
  logic [CH*OW-1:0] signal_out;

  cic_decim_mc #(.CHANNELS(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .STAGES(NS), .RATE_WIDTH(RW)) dut (
    .clk_120mhz(clk_120mhz), .reset(reset), .enable(enable), .rate(rate), .shift(shift),
    .in_strobe(in_strobe), .signal_in(signal_in), .out_strobe(out_strobe), .signal_out(signal_out)
  );

  initial forever #5 clk_120mhz = ~clk_120mhz;

  typedef struct { int due; longint y0; longint y1; } pend_t;
  typedef struct { int due; logic [CH*OW-1:0] val; } exp_t;

  pend_t            pend_q[$];
  exp_t             exp_q[$];
  logic [CH*IW-1:0] hist[$];
  longint           dec[$];
  int               m_cnt, cyc, tests, fails;
  int               n_out, last_strobe, last_period;
  logic [CH*OW-1:0] last_out;
  exp_t             mon_x;

  function automatic longint binom(int n, int k);
    longint r = 1;
    for (int t = 1; t <= k; t++) r = (r * longint'(n - k + t)) / longint'(t);
    return r;
  endfunction

  function automatic longint wrap(longint v);
    return (v <<< (64 - AW)) >>> (64 - AW);
  endfunction

  function automatic longint samp(int i, int c);
    logic [IW-1:0] s;
    s = hist[i][c*IW +: IW];
    return longint'($signed(s));
  endfunction

  // NS-fold running sum of channel c evaluated at sample index j (closed form).
  function automatic longint cum_n(int j, int c);
    longint acc = 0;
    for (int i = 0; i <= j; i++) acc += binom(j - i + NS - 1, NS - 1) * samp(i, c);
    return wrap(acc);
  endfunction

  // NS-th backward difference of the decimated sequence at decimation index j.
  function automatic longint comb_n(int j, int c);
    longint acc = 0;
    for (int i = 0; i <= NS; i++) begin
      if (j - i >= 0) begin
        if (i % 2 == 1) acc -= binom(NS, i) * dec[(j - i) * CH + c];
        else            acc += binom(NS, i) * dec[(j - i) * CH + c];
      end
    end
    return wrap(acc);
  endfunction

  function automatic logic [OW-1:0] norm(longint y, int sh);
    longint v;
    if (sh >= AW) v = (y < 0) ? -64'sd1 : 64'sd0;
    else begin
      v = y;
      if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
      v = v >>> sh;
    end
    if (v > 64'sd32767) v = 64'sd32767;
    else if (v < -64'sd32768) v = -64'sd32768;
    return v[OW-1:0];
  endfunction

  function automatic longint ch_of(logic [CH*OW-1:0] v, int c);
    logic [OW-1:0] s;
    s = v[c*OW +: OW];
    return longint'($signed(s));
  endfunction

  // Apply the inputs about to be sampled at the next edge to the reference model.
  task automatic model_edge();
    int e, j;
    pend_t p;
    exp_t x;
    e = cyc + 1;
    if (reset || !enable) begin
      pend_q.delete(); hist.delete(); dec.delete(); m_cnt = 0;
    end else begin
      while (pend_q.size() > 0 && pend_q[0].due == e) begin
        p = pend_q.pop_front();
        x.due = e;
        x.val = {norm(p.y1, int'(shift)), norm(p.y0, int'(shift))};
        exp_q.push_back(x);
      end
      if (in_strobe) begin
        hist.push_back(signal_in);
        if (m_cnt == 0) begin
          j = hist.size() - NS;
          dec.push_back(cum_n(j, 0));
          dec.push_back(cum_n(j, 1));
          p.due = e + 2;
          p.y0 = comb_n(dec.size() / CH - 1, 0);
          p.y1 = comb_n(dec.size() / CH - 1, 1);
          pend_q.push_back(p);
          m_cnt = (rate <= 8'd1) ? 0 : int'(rate) - 1;
        end else m_cnt--;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_120mhz);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic check(string name, longint got, longint req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic set_in(int a, int b);
    signal_in = {IW'(b), IW'(a)};
  endtask

  // Monitor: every out_strobe must match the oldest expected entry, at its due cycle.
  initial begin
    forever begin
      @(negedge clk_120mhz);
      if (out_strobe === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: cycle %0d got strobe with %h, required no strobe", cyc, signal_out);
        end else begin
          mon_x = exp_q.pop_front();
          if (mon_x.due != cyc || signal_out !== mon_x.val) begin
            fails++;
            $display("FAIL output: cycle %0d got %h, required %h at cycle %0d", cyc, signal_out, mon_x.val, mon_x.due);
          end
        end
        if (n_out > 0) last_period = cyc - last_strobe;
        last_strobe = cyc;
        last_out = signal_out;
        n_out++;
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_strobe: cycle %0d got no strobe, required %h", cyc, exp_q[0].val);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; m_cnt = 0;
    n_out = 0; last_strobe = 0; last_period = 0; last_out = '0;
    reset = 1'b1; enable = 1'b0; rate = 8'd32; shift = 6'd20; in_strobe = 1'b0; signal_in = '0;
    repeat (3) tick();
    check("reset_signal_out", longint'(signal_out), 0);
    check("reset_out_strobe", longint'(out_strobe), 0);

    // DC +1/-1 at R=32, gain 2^20 removed by shift 20
    reset = 1'b0; enable = 1'b1; in_strobe = 1'b1; set_in(1, -1);
    repeat (32 * 8) tick();
    check("dc_r32_ch0", ch_of(last_out, 0), 1);
    check("dc_r32_ch1", ch_of(last_out, 1), -1);
    check("dc_r32_period", last_period, 32);

    shift = 6'd0;
    repeat (64) tick();
    check("sat_ch0", ch_of(last_out, 0), 32767);
    check("sat_ch1", ch_of(last_out, 1), -32768);
    shift = 6'd19;
    repeat (64) tick();
    check("shift19_ch0", ch_of(last_out, 0), 2);
    check("shift19_ch1", ch_of(last_out, 1), -2);

    // R=4 with in_strobe on alternate cycles
    reset = 1'b1; tick(); reset = 1'b0;
    rate = 8'd4; shift = 6'd8; set_in(3, -5);
    for (int i = 0; i < 160; i++) begin
      in_strobe = (i % 2 == 0);
      tick();
    end
    check("alt_ch0", ch_of(last_out, 0), 3);
    check("alt_ch1", ch_of(last_out, 1), -5);
    check("alt_period", last_period, 8);

    enable = 1'b0; in_strobe = 1'b1;
    repeat (3) tick();
    check("disable_hold_ch0", ch_of(signal_out, 0), 3);
    check("disable_hold_ch1", ch_of(signal_out, 1), -5);
    check("disable_strobe", longint'(out_strobe), 0);

    // rate 0 behaves as R=1: ramp on ch0, random samples on ch1
    enable = 1'b1; rate = 8'd0; shift = 6'd0;
    for (int i = 0; i < 40; i++) begin
      set_in(i, int'($urandom_range(0, 65535)) - 32768);
      tick();
    end
    check("r1_period", last_period, 1);

    // rate change 32 -> 8 mid-period
    reset = 1'b1; tick(); reset = 1'b0;
    rate = 8'd32; shift = 6'd12; set_in(1234, -777);
    repeat (10) tick();
    rate = 8'd8;
    repeat (22 + 8 * 8) tick();
    check("rate_change_ch0", ch_of(last_out, 0), 1234);
    check("rate_change_ch1", ch_of(last_out, 1), -777);

    // reset between dstrobe and out_strobe cancels the pending output
    reset = 1'b1; tick(); reset = 1'b0;
    rate = 8'd2; shift = 6'd4; set_in(100, -100);
    repeat (20) tick();
    for (int i = 0; i < 10 && m_cnt != 0; i++) tick();
    tick();
    reset = 1'b1; tick(); reset = 1'b0; in_strobe = 1'b0;
    check("cancel_signal_out", longint'(signal_out), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cancel_strobe", longint'(out_strobe), 0);
    end
    in_strobe = 1'b1;
    repeat (20) tick();

    // randomized traffic
    rate = 8'd3; shift = 6'd10;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) == 0) rate = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) shift = 6'($urandom_range(0, 63));
      else if ($urandom_range(0, 49) == 0) shift = 6'($urandom_range(0, 14));
      reset = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 199) != 0);
      in_strobe = ($urandom_range(0, 3) != 0);
      signal_in = $urandom;
      tick();
    end

    reset = 1'b0; enable = 1'b1; in_strobe = 1'b0;
    repeat (6) tick();
    check("drained", longint'(pend_q.size() + exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
